// File: rtl/wr_fifo_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wr_fifo_arbiter_pkg
//   Shared definitions for the write-FIFO arbiter and its word packer:
//   FSM state encoding, beat/word widths and the round-robin pointer width
//   helper.
// -----------------------------------------------------------------------------
package wr_fifo_arbiter_pkg;

  // Arbiter FSM encoding: IDLE=0, XFER=1, DRAIN=2.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // One requester beat; a FIFO word is always two beats.
  localparam int BEAT_W = 64;
  localparam int WORD_W = 2 * BEAT_W;

  // Pointer width able to index n requesters (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : wr_fifo_arbiter_pkg

// File: rtl/wr_fifo_word_packer.sv
// -----------------------------------------------------------------------------
// wr_fifo_word_packer
//   Packs two 64-bit beats into one 128-bit FIFO word (first beat -> [127:64],
//   second beat -> [63:0]) and holds it in a single-entry output register until
//   the FIFO accepts it.
//
// Ports
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_beat             beat data from the granted requester
//   i_we               beat valid (already qualified by the arbiter)
//   i_fifo_full        write FIFO full
//   o_word             FIFO write data (output register)
//   o_fifo_we          FIFO write enable
//   o_stall            backpressure toward the granted requester
//   o_word_accepted    pulse: the second beat of a word was accepted this cycle
//   o_out_valid        output register holds a word not yet written
//
// Handshake: a beat transfers in a cycle where i_we=1 and o_stall=0. A beat
// offered while o_stall=1 is dropped and no state changes. The FIFO side
// writes whenever the output register is valid and the FIFO is not full.
// -----------------------------------------------------------------------------
module wr_fifo_word_packer
  import wr_fifo_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [BEAT_W-1:0] i_beat,
  input  logic              i_we,
  input  logic              i_fifo_full,
  output logic [WORD_W-1:0] o_word,
  output logic              o_fifo_we,
  output logic              o_stall,
  output logic              o_word_accepted,
  output logic              o_out_valid
);

  logic              half_q, half_d;
  logic [BEAT_W-1:0] hi_q, hi_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              out_valid_q, out_valid_d;
  logic              beat_acc;

  // Stall only while a finished word is blocked by a full FIFO. If the
  // register is draining this cycle, a new word may load behind it.
  assign o_stall         = out_valid_q & i_fifo_full;
  assign o_fifo_we       = out_valid_q & ~i_fifo_full;
  assign beat_acc        = i_we & ~o_stall;
  assign o_word_accepted = beat_acc & half_q;
  assign o_word          = word_q;
  assign o_out_valid     = out_valid_q;

  always_comb begin
    half_d      = half_q;
    hi_d        = hi_q;
    word_d      = word_q;
    out_valid_d = out_valid_q & ~o_fifo_we;
    if (beat_acc) begin
      half_d = ~half_q;
      if (!half_q) begin
        hi_d = i_beat;
      end else begin
        word_d      = {hi_q, i_beat};
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      half_q      <= 1'b0;
      hi_q        <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      half_q      <= half_d;
      hi_q        <= hi_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule : wr_fifo_word_packer

// File: rtl/wr_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// wr_fifo_arbiter
//   Shares one 128-bit flash write FIFO between NUM_REQ 64-bit requesters.
//   One requester at a time is granted for a burst of i_req_len words;
//   requesters are served round-robin between bursts. The granted requester's
//   beats are packed into FIFO words by wr_fifo_word_packer.
//
// Parameters
//   NUM_REQ             number of requesters (2..4)
//   WR_FIFO_DATA_WIDTH  FIFO word width, fixed at 128 (two beats)
//   LEN_WIDTH           burst length field width, in FIFO words
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req               per-requester burst request (level)
//   i_req_len           per-requester burst length, slice r*LEN_WIDTH
//   o_grant             one-hot grant (registered)
//   i_data, i_we        per-requester beat data / beat valid
//   o_full              per-requester backpressure
//   o_done              one-cycle pulse after a burst's last FIFO write
//   o_wr_fifo_data/_we  FIFO write port
//   i_wr_fifo_full      FIFO full
//   o_dbg_state         current FSM state
//
// Handshake: a beat from the granted requester transfers in a cycle where its
// i_we=1 and its o_full=0. Non-granted requesters always see o_full=1 and
// their i_we is ignored. o_wr_fifo_we only asserts when i_wr_fifo_full=0.
// -----------------------------------------------------------------------------
module wr_fifo_arbiter
  import wr_fifo_arbiter_pkg::*;
#(
  parameter int NUM_REQ            = 2,
  parameter int WR_FIFO_DATA_WIDTH = 128,
  parameter int LEN_WIDTH          = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   i_req_len,
  output logic [NUM_REQ-1:0]             o_grant,
  input  logic [NUM_REQ*BEAT_W-1:0]      i_data,
  input  logic [NUM_REQ-1:0]             i_we,
  output logic [NUM_REQ-1:0]             o_full,
  output logic [NUM_REQ-1:0]             o_done,
  output logic [WR_FIFO_DATA_WIDTH-1:0]  o_wr_fifo_data,
  output logic                           o_wr_fifo_we,
  input  logic                           i_wr_fifo_full,
  output logic [1:0]                     o_dbg_state
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  arb_state_e            state_q, state_d;
  logic [PTR_W-1:0]      winner_q, winner_d;
  logic [PTR_W-1:0]      last_q, last_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [LEN_WIDTH-1:0]  words_left_q, words_left_d;

  // Round-robin candidate search
  logic [PTR_W-1:0]      rr_idx;
  logic [PTR_W-1:0]      cand;
  logic                  rr_found;
  logic [LEN_WIDTH-1:0]  rr_len;

  // Packer interface
  logic [BEAT_W-1:0]     sel_beat;
  logic                  sel_we;
  logic [WORD_W-1:0]     pk_word;
  logic                  pk_fifo_we;
  logic                  pk_stall;
  logic                  pk_word_acc;
  logic                  pk_out_valid;

  // FSM transition events shared by the next-state and output processes
  logic                  start_burst;
  logic                  drain_done;

  // ---------------------------------------------------------------------------
  // Round-robin: scan from (last winner + 1) mod NUM_REQ, wrapping once.
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_idx   = last_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(last_q) + k) % NUM_REQ);
      if (!rr_found && i_req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign rr_len = i_req_len[rr_idx*LEN_WIDTH +: LEN_WIDTH];

  // ---------------------------------------------------------------------------
  // Beat mux: only the granted requester reaches the packer, and only in XFER.
  // ---------------------------------------------------------------------------
  assign sel_beat = i_data[winner_q*BEAT_W +: BEAT_W];
  assign sel_we   = i_we[winner_q] & (state_q == ST_XFER);

  wr_fifo_word_packer u_packer (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_beat          (sel_beat),
    .i_we            (sel_we),
    .i_fifo_full     (i_wr_fifo_full),
    .o_word          (pk_word),
    .o_fifo_we       (pk_fifo_we),
    .o_stall         (pk_stall),
    .o_word_accepted (pk_word_acc),
    .o_out_valid     (pk_out_valid)
  );

  // A burst may finish in the same cycle its last word is written, so that
  // o_done and the grant release land one cycle after that write.
  assign start_burst = (state_q == ST_IDLE) & rr_found;
  assign drain_done  = (state_q == ST_DRAIN) & (~pk_out_valid | pk_fifo_we);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      winner_q     <= '0;
      last_q       <= PTR_W'(NUM_REQ - 1);
      words_left_q <= '0;
      grant_q      <= '0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_q       <= last_d;
      words_left_q <= words_left_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_d       = last_q;
    words_left_d = words_left_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_burst) begin
          winner_d     = rr_idx;
          words_left_d = rr_len;
          state_d      = (rr_len == '0) ? ST_DRAIN : ST_XFER;
        end
      end
      ST_XFER: begin
        if (pk_word_acc) begin
          words_left_d = words_left_q - LEN_WIDTH'(1);
          if (words_left_q == LEN_WIDTH'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          last_d  = winner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (registered grant/done next values, combinational o_full)
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_d = grant_q;
    done_d  = '0;
    o_full  = '1;
    if (start_burst) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        grant_d[r] = (rr_idx == PTR_W'(r));
      end
    end
    if (drain_done) begin
      grant_d          = '0;
      done_d[winner_q] = 1'b1;
    end
    if (state_q == ST_XFER) begin
      o_full[winner_q] = pk_stall;
    end
  end

  assign o_grant        = grant_q;
  assign o_done         = done_q;
  assign o_wr_fifo_data = pk_word;
  assign o_wr_fifo_we   = pk_fifo_we;
  assign o_dbg_state    = state_q;

endmodule : wr_fifo_arbiter

// File: tb/tb_wr_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wr_fifo_arbiter
//   Directed bench for wr_fifo_arbiter (NUM_REQ=2). Inputs change 2 time units
//   after each rising edge; outputs are checked 1 unit later. FIFO writes are
//   collected on the falling edge and compared against an expected queue.
// -----------------------------------------------------------------------------
module tb_wr_fifo_arbiter;

  localparam int NR = 2;
  localparam int LW = 8;

  // clock / reset
  logic          i_clk;
  logic          i_rst_n;
  logic [NR-1:0]    i_req;
  logic [NR*LW-1:0] i_req_len;
  logic [NR-1:0]    o_grant;
  logic [NR*64-1:0] i_data;
  logic [NR-1:0]    i_we;
  logic [NR-1:0]    o_full;
  logic [NR-1:0]    o_done;
  logic [127:0]     o_wr_fifo_data;
  logic             o_wr_fifo_we;
  logic             i_wr_fifo_full;
  logic [1:0]       o_dbg_state;

  int n_vec;
  int n_err;

  logic [127:0] exp_q[$];
  logic [127:0] wr_q[$];
  logic [1:0]   g;

  localparam logic [63:0] BA = 64'hA000_0000_0000_000A;
  localparam logic [63:0] BB = 64'hB000_0000_0000_000B;
  localparam logic [63:0] BC = 64'hC000_0000_0000_000C;
  localparam logic [63:0] BD = 64'hD000_0000_0000_000D;
  localparam logic [63:0] RA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RB = 64'h5555_6666_7777_8888;
  localparam logic [63:0] BP = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] BQ = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] BX = 64'hDEAD_BEEF_DEAD_BEEF;

  wr_fifo_arbiter #(
    .NUM_REQ            (NR),
    .WR_FIFO_DATA_WIDTH (128),
    .LEN_WIDTH          (LW)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_req          (i_req),
    .i_req_len      (i_req_len),
    .o_grant        (o_grant),
    .i_data         (i_data),
    .i_we           (i_we),
    .o_full         (o_full),
    .o_done         (o_done),
    .o_wr_fifo_data (o_wr_fifo_data),
    .o_wr_fifo_we   (o_wr_fifo_we),
    .i_wr_fifo_full (i_wr_fifo_full),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // FIFO write monitor
  always @(negedge i_clk) begin
    if (i_rst_n && o_wr_fifo_we) wr_q.push_back(o_wr_fifo_data);
  end

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic beat(input int r, input logic [63:0] d, input logic we);
    i_data[r*64 +: 64] = d;
    i_we[r]            = we;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 128'(wr_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk({tag, "_wdata"}, wr_q[i], exp_q[i]);
    end
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    i_rst_n        = 1'b0;
    i_req          = '0;
    i_req_len      = '0;
    i_data         = '0;
    i_we           = '0;
    i_wr_fifo_full = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    wr_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    n_vec = 0;
    n_err = 0;

    // ---- reset values + single burst, len=2 ----
    do_reset();
    #1;
    chk("rst_grant", 128'(o_grant), 128'(2'b00));
    chk("rst_full",  128'(o_full),  128'(2'b11));
    chk("rst_done",  128'(o_done),  128'(2'b00));
    chk("rst_we",    128'(o_wr_fifo_we), 128'(1'b0));
    chk("rst_data",  o_wr_fifo_data, 128'h0);
    chk("rst_state", 128'(o_dbg_state), 128'(2'd0));
    i_req = 2'b01; i_req_len[7:0] = 8'd2;
    tick();                                   // cycle 1: grant
    i_req = 2'b00; beat(0, BA, 1'b1); #1;
    chk("s1_grant", 128'(o_grant), 128'(2'b01));
    chk("s1_full",  128'(o_full),  128'(2'b10));
    chk("s1_state", 128'(o_dbg_state), 128'(2'd1));
    tick();                                   // cycle 2
    beat(0, BB, 1'b1);
    tick();                                   // cycle 3: {A,B} written
    beat(0, BC, 1'b1); #1;
    chk("s1_we1",   128'(o_wr_fifo_we), 128'(1'b1));
    chk("s1_data1", o_wr_fifo_data, {BA, BB});
    tick();                                   // cycle 4
    beat(0, BD, 1'b1); #1;
    chk("s1_we_gap", 128'(o_wr_fifo_we), 128'(1'b0));
    tick();                                   // cycle 5: {C,D} written, DRAIN
    beat(0, 64'h0, 1'b0); #1;
    chk("s1_we2",    128'(o_wr_fifo_we), 128'(1'b1));
    chk("s1_data2",  o_wr_fifo_data, {BC, BD});
    chk("s1_drain",  128'(o_dbg_state), 128'(2'd2));
    chk("s1_grant2", 128'(o_grant), 128'(2'b01));
    tick();                                   // cycle 6: done
    #1;
    chk("s1_done",   128'(o_done),  128'(2'b01));
    chk("s1_gnt_off", 128'(o_grant), 128'(2'b00));
    chk("s1_we_off", 128'(o_wr_fifo_we), 128'(1'b0));
    tick();                                   // cycle 7
    #1;
    chk("s1_done_pulse", 128'(o_done), 128'(2'b00));
    chk("s1_idle",   128'(o_dbg_state), 128'(2'd0));
    exp_q.push_back({BA, BB});
    exp_q.push_back({BC, BD});
    check_writes("s1");

    // ---- round-robin, both requesting, len=1 each ----
    do_reset();
    i_req = 2'b11; i_req_len = {8'd1, 8'd1};
    beat(0, RA, 1'b1); beat(1, RB, 1'b1);
    for (int b = 0; b < 4; b++) begin
      g = (b % 2 == 0) ? 2'b01 : 2'b10;
      tick(); #1;                             // cycle 4b+1
      chk("rr_grant", 128'(o_grant), 128'(g));
      tick(); tick(); #1;                     // cycle 4b+3
      chk("rr_we",   128'(o_wr_fifo_we), 128'(1'b1));
      chk("rr_data", o_wr_fifo_data, (b % 2 == 0) ? {RA, RA} : {RB, RB});
      tick(); #1;                             // cycle 4b+4
      chk("rr_done",    128'(o_done),  128'(g));
      chk("rr_gnt_off", 128'(o_grant), 128'(2'b00));
      exp_q.push_back((b % 2 == 0) ? {RA, RA} : {RB, RB});
    end
    i_req = 2'b00; i_we = 2'b00;
    tick(); tick();
    check_writes("rr");

    // ---- FIFO full stall, with one dropped protocol-violating beat ----
    do_reset();
    i_req = 2'b01; i_req_len[7:0] = 8'd2;
    tick();                                   // cycle 1
    i_req = 2'b00; beat(0, BA, 1'b1);
    tick();                                   // cycle 2
    beat(0, BB, 1'b1);
    tick();                                   // cycle 3: word ready, FIFO full
    i_wr_fifo_full = 1'b1; beat(0, BX, 1'b1); #1;
    chk("st_full0", 128'(o_full), 128'(2'b11));
    chk("st_we0",   128'(o_wr_fifo_we), 128'(1'b0));
    tick();                                   // cycle 4
    beat(0, BC, 1'b0); #1;
    chk("st_full1", 128'(o_full), 128'(2'b11));
    chk("st_we1",   128'(o_wr_fifo_we), 128'(1'b0));
    tick(); tick(); tick();                   // cycle 7
    #1;
    chk("st_full4", 128'(o_full), 128'(2'b11));
    chk("st_we4",   128'(o_wr_fifo_we), 128'(1'b0));
    tick();                                   // cycle 8: FIFO free
    i_wr_fifo_full = 1'b0; beat(0, BC, 1'b1); #1;
    chk("st_full_rel", 128'(o_full), 128'(2'b10));
    chk("st_we_rel",   128'(o_wr_fifo_we), 128'(1'b1));
    chk("st_data_rel", o_wr_fifo_data, {BA, BB});
    tick();                                   // cycle 9
    beat(0, BD, 1'b1);
    tick();                                   // cycle 10
    beat(0, 64'h0, 1'b0); #1;
    chk("st_we2",   128'(o_wr_fifo_we), 128'(1'b1));
    chk("st_data2", o_wr_fifo_data, {BC, BD});
    tick();                                   // cycle 11
    #1;
    chk("st_done", 128'(o_done), 128'(2'b01));
    exp_q.push_back({BA, BB});
    exp_q.push_back({BC, BD});
    check_writes("st");

    // ---- zero-length burst, then isolation of a non-granted requester ----
    do_reset();
    i_req = 2'b10; i_req_len = {8'd0, 8'd0};
    tick();                                   // cycle 1: grant r1, DRAIN
    i_req = 2'b00; beat(0, BX, 1'b1); #1;
    chk("z_grant", 128'(o_grant), 128'(2'b10));
    chk("z_state", 128'(o_dbg_state), 128'(2'd2));
    chk("z_full",  128'(o_full), 128'(2'b11));
    chk("z_we",    128'(o_wr_fifo_we), 128'(1'b0));
    tick();                                   // cycle 2: done
    beat(0, BA, 1'b0); #1;
    chk("z_done",    128'(o_done),  128'(2'b10));
    chk("z_gnt_off", 128'(o_grant), 128'(2'b00));
    i_req = 2'b10; i_req_len = {8'd1, 8'd0};
    tick();                                   // cycle 3: grant r1, XFER
    i_req = 2'b00; beat(0, BB, 1'b1); beat(1, BP, 1'b1); #1;
    chk("iso_grant", 128'(o_grant), 128'(2'b10));
    chk("iso_full",  128'(o_full),  128'(2'b01));
    tick();                                   // cycle 4
    beat(0, BC, 1'b0); beat(1, BQ, 1'b1);
    tick();                                   // cycle 5: {P,Q} written
    beat(1, 64'h0, 1'b0); beat(0, BD, 1'b1); #1;
    chk("iso_we",   128'(o_wr_fifo_we), 128'(1'b1));
    chk("iso_data", o_wr_fifo_data, {BP, BQ});
    tick();                                   // cycle 6
    beat(0, 64'h0, 1'b0); #1;
    chk("iso_done", 128'(o_done), 128'(2'b10));
    tick(); tick();
    exp_q.push_back({BP, BQ});
    check_writes("iso");

    // ---- mid-burst asynchronous reset ----
    do_reset();
    i_req = 2'b11; i_req_len = {8'd4, 8'd4};
    tick();                                   // cycle 1
    beat(0, BA, 1'b1);
    tick();                                   // cycle 2
    beat(0, BB, 1'b1);
    tick();                                   // cycle 3: {A,B} written
    beat(0, BC, 1'b1);
    tick();                                   // cycle 4: C held as partial
    beat(0, 64'h0, 1'b0);
    i_rst_n = 1'b0; #1;
    chk("mr_grant", 128'(o_grant), 128'(2'b00));
    chk("mr_we",    128'(o_wr_fifo_we), 128'(1'b0));
    chk("mr_full",  128'(o_full), 128'(2'b11));
    chk("mr_data",  o_wr_fifo_data, 128'h0);
    chk("mr_state", 128'(o_dbg_state), 128'(2'd0));
    i_req = 2'b10;
    tick(); tick();
    i_rst_n = 1'b1;
    tick(); #1;
    chk("mr_grant_r1", 128'(o_grant), 128'(2'b10));
    i_req = 2'b00;
    tick(); tick();
    exp_q.push_back({BA, BB});
    check_writes("mr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_wr_fifo_arbiter
